dsp_mac_pipe: RTL and testbench

Parametrised, fully pipelined signed multiply-accumulate slice. It is the next generation of the team's DSP48A1-style slice, with generic operand widths and a per-sample opmode that travels with its data. It adds valid/ready flow control and accumulation framing (last-sample restart). It sits in datapath filters and chains through pcin/pcout to neighbouring slices.

---
 rtl/dsp_mac_pipe_if.sv | 36 +++
 rtl/dsp_mac_pipe.sv | 183 ++++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_pipe_if.sv
// dsp_mac_pipe_if: sample/result handshake bundle for the dsp_mac_pipe slice.
// The master modport drives samples and consumes results; the slave modport is the slice.
interface dsp_mac_pipe_if #(
    parameter int unsigned A_WIDTH = 18,
    parameter int unsigned B_WIDTH = 18,
    parameter int unsigned C_WIDTH = 48,
    parameter int unsigned P_WIDTH = 48
);
    logic                       in_valid;
    logic                       in_ready;
    logic [A_WIDTH-1:0]         a;
    logic [B_WIDTH-1:0]         b;
    logic [B_WIDTH-1:0]         d;
    logic [C_WIDTH-1:0]         c;
    logic [5:0]                 opmode;
    logic                       in_last;
    logic [P_WIDTH-1:0]         pcin;
    logic                       out_valid;
    logic                       out_ready;
    logic [P_WIDTH-1:0]         p;
    logic [P_WIDTH-1:0]         pcout;
    logic [A_WIDTH+B_WIDTH-1:0] m;
    logic                       carryout;
    logic                       out_last;
    logic                       ovf;

    modport master (
        output in_valid, a, b, d, c, opmode, in_last, pcin, out_ready,
        input  in_ready, out_valid, p, pcout, m, carryout, out_last, ovf
    );

    modport slave (
        input  in_valid, a, b, d, c, opmode, in_last, pcin, out_ready,
        output in_ready, out_valid, p, pcout, m, carryout, out_last, ovf
    );
endinterface

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: 4-stage signed pre-add/multiply/post-add/accumulate slice with valid/ready flow control.
// Define DSP_MAC_SAT_EN to saturate P on signed overflow and report it on ovf; otherwise P wraps.
module dsp_mac_pipe #(
    parameter int unsigned A_WIDTH = 18,
    parameter int unsigned B_WIDTH = 18,
    parameter int unsigned C_WIDTH = 48,
    parameter int unsigned P_WIDTH = 48
) (
    input  logic          clk,
    input  logic          rst,
    dsp_mac_pipe_if.slave s_if
);
    localparam int unsigned M_WIDTH = A_WIDTH + B_WIDTH;
    localparam int unsigned U_WIDTH = P_WIDTH + 1;

    localparam logic [1:0] ZSEL_ZERO = 2'd0;
    localparam logic [1:0] ZSEL_PCIN = 2'd1;
    localparam logic [1:0] ZSEL_ACC  = 2'd2;
    localparam logic [1:0] ZSEL_C    = 2'd3;

    logic                        w_en;
    logic                        r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid;
    logic signed [A_WIDTH-1:0]   r_s1_a, r_s2_a;
    logic signed [B_WIDTH-1:0]   r_s1_b, r_s1_d, r_s2_pre, w_pre;
    logic signed [C_WIDTH-1:0]   r_s1_c, r_s2_c, r_s3_c;
    logic [5:0]                  r_s1_op;
    logic [3:0]                  r_s2_op, r_s3_op;   // {carry_in, post_sub, zsel}
    logic                        r_s1_last, r_s2_last, r_s3_last, r_s4_last;
    logic signed [M_WIDTH-1:0]   r_m, w_mult;
    logic signed [P_WIDTH-1:0]   w_x, w_z, w_c_ext, w_pwrap;
    logic [U_WIDTH-1:0]          w_usum;
    logic [P_WIDTH-1:0]          r_p, w_pnext;
    logic                        r_carry, r_ovf, w_ovf, r_restart;

    // One global enable: everything advances unless a result is stuck at the output.
    assign w_en          = !r_s4_valid || s_if.out_ready;
    assign s_if.in_ready = w_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_d     <= '0;
            r_s1_c     <= '0;
            r_s1_op    <= '0;
            r_s1_last  <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= s_if.in_valid;
            if (s_if.in_valid) begin
                r_s1_a    <= s_if.a;
                r_s1_b    <= s_if.b;
                r_s1_d    <= s_if.d;
                r_s1_c    <= s_if.c;
                r_s1_op   <= s_if.opmode;
                r_s1_last <= s_if.in_last;
            end
        end
    end

    always_comb begin
        w_pre = r_s1_b;
        if (r_s1_op[0])
            w_pre = r_s1_op[1] ? (r_s1_d - r_s1_b) : (r_s1_d + r_s1_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_a     <= '0;
            r_s2_pre   <= '0;
            r_s2_c     <= '0;
            r_s2_op    <= '0;
            r_s2_last  <= 1'b0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_a    <= r_s1_a;
                r_s2_pre  <= w_pre;
                r_s2_c    <= r_s1_c;
                r_s2_op   <= r_s1_op[5:2];
                r_s2_last <= r_s1_last;
            end
        end
    end

    assign w_mult = M_WIDTH'(r_s2_a) * M_WIDTH'(r_s2_pre);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_valid <= 1'b0;
            r_m        <= '0;
            r_s3_c     <= '0;
            r_s3_op    <= '0;
            r_s3_last  <= 1'b0;
        end else if (w_en) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_m       <= w_mult;
                r_s3_c    <= r_s2_c;
                r_s3_op   <= r_s2_op;
                r_s3_last <= r_s2_last;
            end
        end
    end

    assign w_x     = P_WIDTH'(r_m);
    assign w_c_ext = P_WIDTH'(r_s3_c);

    always_comb begin
        w_z = '0;
        case (r_s3_op[1:0])
            ZSEL_ZERO: w_z = '0;
            ZSEL_PCIN: w_z = s_if.pcin;
            ZSEL_ACC:  w_z = r_restart ? '0 : r_p;
            ZSEL_C:    w_z = w_c_ext;
            default:   w_z = '0;
        endcase
    end

    // Carry/borrow comes from the unsigned (P+1)-bit view of the post-adder.
    always_comb begin
        if (r_s3_op[2])
            w_usum = {1'b0, w_z} - {1'b0, w_x} - U_WIDTH'(r_s3_op[3]);
        else
            w_usum = {1'b0, w_z} + {1'b0, w_x} + U_WIDTH'(r_s3_op[3]);
    end

    assign w_pwrap = w_usum[P_WIDTH-1:0];

`ifdef DSP_MAC_SAT_EN
    localparam int unsigned S_WIDTH = P_WIDTH + 2;

    logic [S_WIDTH-1:0] w_ssum;

    // Exact signed sum; overflow whenever it differs from the wrapped P value.
    always_comb begin
        if (r_s3_op[2])
            w_ssum = S_WIDTH'(w_z) - S_WIDTH'(w_x) - S_WIDTH'(r_s3_op[3]);
        else
            w_ssum = S_WIDTH'(w_z) + S_WIDTH'(w_x) + S_WIDTH'(r_s3_op[3]);
    end

    always_comb begin
        w_ovf   = (w_ssum != S_WIDTH'(w_pwrap));
        w_pnext = w_pwrap;
        if (w_ovf)
            w_pnext = w_ssum[S_WIDTH-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                                        : {1'b0, {(P_WIDTH-1){1'b1}}};
    end
`else
    assign w_ovf   = 1'b0;
    assign w_pnext = w_pwrap;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s4_valid <= 1'b0;
            r_p        <= '0;
            r_carry    <= 1'b0;
            r_s4_last  <= 1'b0;
            r_ovf      <= 1'b0;
            r_restart  <= 1'b1;
        end else if (w_en) begin
            r_s4_valid <= r_s3_valid;
            if (r_s3_valid) begin
                r_p       <= w_pnext;
                r_carry   <= w_usum[P_WIDTH];
                r_s4_last <= r_s3_last;
                r_ovf     <= w_ovf;
                r_restart <= r_s3_last;
            end
        end
    end

    assign s_if.out_valid = r_s4_valid;
    assign s_if.p         = r_p;
    assign s_if.pcout     = r_p;
    assign s_if.m         = r_m;
    assign s_if.carryout  = r_carry;
    assign s_if.out_last  = r_s4_last;
    assign s_if.ovf       = r_ovf;
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe: directed vectors with a scoreboard queue checked by an independent output monitor.
`timescale 1ns/1ps
module tb_dsp_mac_pipe;
    localparam int unsigned AW = 18;
    localparam int unsigned BW = 18;
    localparam int unsigned CW = 48;
    localparam int unsigned PW = 48;
    localparam int unsigned MW = AW + BW;

`ifdef DSP_MAC_SAT_EN
    localparam logic [PW-1:0] SAT_P   = 48'h7FFF_FFFF_FFFF;
    localparam logic          SAT_OVF = 1'b1;
`else
    localparam logic [PW-1:0] SAT_P   = 48'h8000_0000_0000;
    localparam logic          SAT_OVF = 1'b0;
`endif

    typedef struct {
        logic [PW-1:0] p;
        logic          carry;
        logic          last;
        logic          ovf;
        logic          chk_m;
        logic [MW-1:0] m;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_hs     = 0;

    always #5 clk = ~clk;

    dsp_mac_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .C_WIDTH(CW), .P_WIDTH(PW)) bus ();

    dsp_mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .C_WIDTH(CW), .P_WIDTH(PW)) dut (
        .clk  (clk),
        .rst  (rst),
        .s_if (bus.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Output monitor: pops one expectation per completed out_valid/out_ready handshake.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.out_valid && bus.out_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    e = exp_q.pop_front();
                    check("p",        bus.p,        e.p);
                    check("pcout",    bus.pcout,    e.p);
                    check("carryout", bus.carryout, e.carry);
                    check("out_last", bus.out_last, e.last);
                    check("ovf",      bus.ovf,      e.ovf);
                    if (e.chk_m) check("m", bus.m, e.m);
                end
            end
        end
    end

    task automatic send(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [BW-1:0] d,
                        input logic [CW-1:0] c, input logic [5:0] op, input logic last,
                        input logic push, input logic [PW-1:0] ep, input logic ec,
                        input logic eo, input logic chk, input logic [MW-1:0] em);
        logic rdy;
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.d        = d;
        bus.c        = c;
        bus.opmode   = op;
        bus.in_last  = last;
        forever begin
            #1 rdy = bus.in_ready;
            @(posedge clk);
            if (rdy || n >= 50) break;
            n++;
            @(negedge clk);
        end
        if (!rdy) begin
            fail_now("send_timeout");
        end else if (push) begin
            e = '{p: ep, carry: ec, last: last, ovf: eo, chk_m: chk, m: em};
            exp_q.push_back(e);
        end
    endtask

    task automatic mac(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [BW-1:0] d,
                       input logic [CW-1:0] c, input logic [5:0] op, input logic last,
                       input logic [PW-1:0] ep, input logic ec, input logic chk, input logic [MW-1:0] em);
        send(a, b, d, c, op, last, 1'b1, ep, ec, 1'b0, chk, em);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        repeat (2) @(posedge clk);
    endtask

    initial begin : stimulus
        int hs0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.d         = '0;
        bus.c         = '0;
        bus.opmode    = '0;
        bus.in_last   = 1'b0;
        bus.pcin      = PW'(1000);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_p",         bus.p,         0);
        check("rst_m",         bus.m,         0);
        check("rst_carryout",  bus.carryout,  0);
        check("rst_out_last",  bus.out_last,  0);
        check("rst_ovf",       bus.ovf,       0);
        rst = 1'b0;

        // Multiply only: exactly one result handshake.
        hs0 = n_hs;
        mac(AW'(3), BW'(-4), '0, '0, 6'b000000, 1'b1, PW'(-12), 1'b0, 1'b1, MW'(-12));
        drain();
        check("mult_handshakes", 64'(n_hs - hs0), 1);
        check("mult_valid_drop", bus.out_valid, 0);

        // Pre-adder subtract and add.
        mac(AW'(2), BW'(3),  BW'(10), '0, 6'b000011, 1'b1, PW'(14),  1'b0, 1'b1, MW'(14));
        drain();
        mac(AW'(2), BW'(-4), BW'(-5), '0, 6'b000001, 1'b1, PW'(-18), 1'b0, 1'b1, MW'(-18));
        drain();

        // Cascade input and carry_in.
        mac(AW'(2), BW'(3), '0, '0,          6'b000100, 1'b1, PW'(1006), 1'b0, 1'b1, MW'(6));
        mac(AW'(2), BW'(3), '0, '0,          6'b100000, 1'b1, PW'(7),    1'b0, 1'b1, MW'(6));
        mac(AW'(2), BW'(3), '0, CW'(100),    6'b111100, 1'b1, PW'(93),   1'b0, 1'b1, MW'(6));
        drain();

        // Accumulation framing, then automatic restart after last.
        mac(AW'(1), BW'(1), '0, '0, 6'b001000, 1'b0, PW'(1),  1'b0, 1'b0, '0);
        mac(AW'(2), BW'(1), '0, '0, 6'b001000, 1'b0, PW'(3),  1'b0, 1'b0, '0);
        mac(AW'(3), BW'(1), '0, '0, 6'b001000, 1'b0, PW'(6),  1'b0, 1'b0, '0);
        mac(AW'(4), BW'(1), '0, '0, 6'b001000, 1'b1, PW'(10), 1'b0, 1'b1, MW'(4));
        drain();
        mac(AW'(5), BW'(1), '0, '0, 6'b001000, 1'b1, PW'(5),  1'b0, 1'b1, MW'(5));
        drain();

        // Backpressure: 3-cycle output stall in the middle of an 8-sample accumulation.
        hs0 = n_hs;
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    mac(AW'(i), BW'(1), '0, '0, 6'b001000, (i == 8), PW'(i * (i + 1) / 2),
                        1'b0, (i == 8), MW'(i));
            end
            begin
                repeat (6) @(negedge clk);
                bus.out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    #2;
                    check("stall_in_ready",  bus.in_ready,  0);
                    check("stall_out_valid", bus.out_valid, 1);
                    check("stall_p_held",    bus.p,         3);
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("stream_handshakes", 64'(n_hs - hs0), 8);

        // Carry out of the add, then borrow out of the subtract.
        mac(AW'(1), BW'(1), '0, 48'hFFFF_FFFF_FFFF, 6'b001100, 1'b1, '0,                 1'b1, 1'b1, MW'(1));
        mac(AW'(1), BW'(1), '0, '0,                 6'b011100, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b1, MW'(1));
        drain();

        // Reset with three samples in flight: none of them may emerge.
        hs0 = n_hs;
        send(AW'(7), BW'(7), '0, '0, 6'b000000, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        send(AW'(8), BW'(7), '0, '0, 6'b000000, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        send(AW'(9), BW'(7), '0, '0, 6'b000000, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        #2;
        check("midrst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        #2;
        check("midrst_in_ready2", bus.in_ready, 1);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #2;
            check("midrst_no_valid", bus.out_valid, 0);
        end
        check("midrst_p", bus.p, 0);
        check("midrst_m", bus.m, 0);
        check("midrst_handshakes", 64'(n_hs - hs0), 0);

        // Signed overflow of the post-adder.
        send(AW'(1), BW'(1), '0, 48'h7FFF_FFFF_FFFF, 6'b001100, 1'b1, 1'b1, SAT_P, 1'b0, SAT_OVF, 1'b1, MW'(1));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
